shift_register_multi: RTL and testbench

SHIFT_REGISTER_MULTI -- requirements
Module: shift_register_multi

---
 rtl/shift_register_pkg.sv | 21 ++
 rtl/clk_div_strobe.sv | 31 +++
 rtl/shift_register_multi.sv | 155 +++++++++++++++
 tb/tb_shift_register_multi.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/shift_register_pkg.sv
// Shared definitions for the multi-lane panel shift-register driver:
// FSM encoding, parameter defaults and counter sizing.
package shift_register_pkg;

  localparam int DEF_CHANNELS     = 16;
  localparam int DEF_BITS         = 8;
  localparam int DEF_DIV          = 1;
  localparam int DEF_LATCH_CYCLES = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_LATCH = 2'd2
  } state_t;

  // Width able to hold 0..count-1; never narrower than one bit.
  function automatic int cnt_w(input int count);
    return (count > 1) ? $clog2(count) : 1;
  endfunction

endpackage

// File: rtl/clk_div_strobe.sv
// Phase strobe generator: while enabled, pulses strobe for one cycle every DIV
// cycles; restarts a full period whenever it is disabled.
module clk_div_strobe
  import shift_register_pkg::*;
#(
  parameter int DIV = DEF_DIV
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic strobe
);

  localparam int           W    = cnt_w(DIV);
  localparam logic [W-1:0] LOAD = W'(DIV - 1);

  logic [W-1:0] cnt;

  assign strobe = en && (cnt == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= LOAD;
    end else if (!en || strobe) begin
      cnt <= LOAD;
    end else begin
      cnt <= cnt - 1'b1;
    end
  end

endmodule

// File: rtl/shift_register_multi.sv
// Serialises CHANNELS parallel lanes LSB first onto sdata with sclk, then pulses
// latch; a pending frame register allows gap-free back-to-back frames.
//   state    | meaning
//   ST_IDLE  | no active frame, sclk/latch low, sdata holds last bit
//   ST_SHIFT | clocking bit idx of the active frame out on every lane
//   ST_LATCH | latch high for LATCH_CYCLES; frame_done on the last one
module shift_register_multi
  import shift_register_pkg::*;
#(
  parameter int CHANNELS     = DEF_CHANNELS,
  parameter int BITS         = DEF_BITS,
  parameter int DIV          = DEF_DIV,
  parameter int LATCH_CYCLES = DEF_LATCH_CYCLES
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [CHANNELS*BITS-1:0] in_data,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic [CHANNELS-1:0]      sdata,
  output logic                     sclk,
  output logic                     latch,
  output logic                     busy,
  output logic                     frame_done
);

  localparam int FW = CHANNELS * BITS;
  localparam int IW = cnt_w(BITS);
  localparam int LW = cnt_w(LATCH_CYCLES);
  localparam logic [IW-1:0] LAST_BIT = IW'(BITS - 1);
  localparam logic [LW-1:0] LAT_LOAD = LW'(LATCH_CYCLES - 1);

  state_t               state, state_n;
  logic [IW-1:0]        idx, idx_n;
  logic [LW-1:0]        lat_cnt, lat_n;
  logic [FW-1:0]        act, act_n, pend, pend_n, act_shift;
  logic                 pend_full, pend_full_n;
  logic                 sclk_n, load_bits, accept, strobe, div_en;
  logic [CHANNELS-1:0]  sdata_n;

  assign in_ready = !pend_full;
  assign accept   = in_valid && !pend_full;
  assign div_en   = (state == ST_SHIFT);

  clk_div_strobe #(.DIV(DIV)) u_div (
    .clk    (clk),
    .rst_n  (rst_n),
    .en     (div_en),
    .strobe (strobe)
  );

  always_comb begin
    state_n     = state;
    idx_n       = idx;
    lat_n       = lat_cnt;
    act_n       = act;
    pend_n      = pend;
    pend_full_n = pend_full;
    sclk_n      = sclk;
    load_bits   = 1'b0;

    case (state)
      ST_IDLE: begin
        sclk_n = 1'b0;
        if (accept) begin
          act_n     = in_data;
          idx_n     = '0;
          state_n   = ST_SHIFT;
          load_bits = 1'b1;
        end
      end
      ST_SHIFT: begin
        if (accept) begin
          pend_n      = in_data;
          pend_full_n = 1'b1;
        end
        if (strobe) begin
          if (!sclk) begin
            sclk_n = 1'b1;
          end else begin
            sclk_n = 1'b0;
            if (idx == LAST_BIT) begin
              state_n = ST_LATCH;
              lat_n   = LAT_LOAD;
            end else begin
              idx_n     = idx + 1'b1;
              load_bits = 1'b1;
            end
          end
        end
      end
      ST_LATCH: begin
        sclk_n = 1'b0;
        if (lat_cnt == '0) begin
          // Pending frame wins; otherwise a frame arriving right now goes straight to active.
          if (pend_full) begin
            act_n       = pend;
            pend_full_n = 1'b0;
            idx_n       = '0;
            state_n     = ST_SHIFT;
            load_bits   = 1'b1;
          end else if (accept) begin
            act_n     = in_data;
            idx_n     = '0;
            state_n   = ST_SHIFT;
            load_bits = 1'b1;
          end else begin
            state_n = ST_IDLE;
          end
        end else begin
          lat_n = lat_cnt - 1'b1;
          if (accept) begin
            pend_n      = in_data;
            pend_full_n = 1'b1;
          end
        end
      end
      default: state_n = ST_IDLE;
    endcase

    act_shift = act_n >> idx_n;
    for (int c = 0; c < CHANNELS; c++) begin
      sdata_n[c] = load_bits ? act_shift[c*BITS] : sdata[c];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      idx        <= '0;
      lat_cnt    <= '0;
      act        <= '0;
      pend       <= '0;
      pend_full  <= 1'b0;
      sdata      <= '0;
      sclk       <= 1'b0;
      latch      <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_n;
      idx        <= idx_n;
      lat_cnt    <= lat_n;
      act        <= act_n;
      pend       <= pend_n;
      pend_full  <= pend_full_n;
      sdata      <= sdata_n;
      sclk       <= sclk_n;
      latch      <= (state_n == ST_LATCH);
      busy       <= (state_n != ST_IDLE);
      frame_done <= (state_n == ST_LATCH) && (lat_n == '0);
    end
  end

endmodule

// File: tb/tb_shift_register_multi.sv
// Bench for shift_register_multi: a frame-queue timing model scores every cycle
// of the default instance; a DIV=3/BITS=4 instance checks slow-clock timing.
module tb_shift_register_multi;

  localparam int CH = 16, BITS = 8, DIV = 1, LATC = 2;
  localparam int SH = 2 * DIV * BITS;
  localparam int PER = SH + LATC;
  localparam int B_CH = 2, B_BITS = 4, B_DIV = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b1;

  logic [CH*BITS-1:0] a_data = '0;
  logic               a_valid = 1'b0;
  logic               a_ready, a_sclk, a_latch, a_busy, a_done;
  logic [CH-1:0]      a_sdata;

  logic [B_CH*B_BITS-1:0] b_data = '0;
  logic                   b_valid = 1'b0;
  logic                   b_ready, b_sclk, b_latch, b_busy, b_done;
  logic [B_CH-1:0]        b_sdata;

  int errors = 0;
  int n_checks = 0;
  int cyc = 0;
  bit sb_en = 1'b1;

  always #5 clk = ~clk;

  shift_register_multi u_dut_a (
    .clk(clk), .rst_n(rst_n), .in_data(a_data), .in_valid(a_valid), .in_ready(a_ready),
    .sdata(a_sdata), .sclk(a_sclk), .latch(a_latch), .busy(a_busy), .frame_done(a_done)
  );

  shift_register_multi #(.CHANNELS(B_CH), .BITS(B_BITS), .DIV(B_DIV), .LATCH_CYCLES(2)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .in_data(b_data), .in_valid(b_valid), .in_ready(b_ready),
    .sdata(b_sdata), .sclk(b_sclk), .latch(b_latch), .busy(b_busy), .frame_done(b_done)
  );

  // Reference model: queue of waiting frames plus position t within the running frame.
  bit                 m_active = 1'b0;
  int                 m_t = 0;
  logic [CH*BITS-1:0] m_act = '0;
  logic [CH*BITS-1:0] m_tmp;
  logic [CH*BITS-1:0] m_q[$];
  logic [CH-1:0]      m_sdata = '0;
  bit                 m_acc;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_active = 1'b0;
      m_t      = 0;
      m_q.delete();
      m_sdata  = '0;
    end else begin
      m_acc = a_valid && (m_q.size() == 0);
      if (m_active) begin
        m_t++;
        if (m_t == PER) m_active = 1'b0;
      end
      if (m_acc) m_q.push_back(a_data);
      if (!m_active && m_q.size() > 0) begin
        m_act    = m_q.pop_front();
        m_active = 1'b1;
        m_t      = 0;
      end
      if (m_active && m_t < SH) begin
        m_tmp = m_act >> (m_t / (2 * DIV));
        for (int c = 0; c < CH; c++) m_sdata[c] = m_tmp[c*BITS];
      end
    end
  end

  typedef struct {
    logic [7:0] base;
    logic [7:0] exp0;
    logic [7:0] exp15;
    int         exp_done;
  } vec_t;
  vec_t vecs[4];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  function automatic logic [CH*BITS-1:0] mk_word(input logic [7:0] base);
    logic [CH*BITS-1:0] w;
    for (int c = 0; c < CH; c++) w[c*8 +: 8] = base ^ 8'(c);
    return w;
  endfunction

  function automatic logic [CH-1:0] bit0_lanes(input logic [CH*BITS-1:0] w);
    logic [CH-1:0] r;
    for (int c = 0; c < CH; c++) r[c] = w[c*BITS];
    return r;
  endfunction

  task automatic tick();
    logic e_sclk, e_latch, e_done;
    @(negedge clk);
    cyc++;
    if (sb_en) begin
      e_sclk  = m_active && (m_t < SH) && ((m_t % (2 * DIV)) >= DIV);
      e_latch = m_active && (m_t >= SH);
      e_done  = m_active && (m_t == PER - 1);
      check("scoreboard", 64'({a_sdata, a_sclk, a_latch, a_busy, a_done, a_ready}),
            64'({m_sdata, e_sclk, e_latch, m_active, e_done, (m_q.size() == 0)}));
    end
  endtask

  task automatic run_vec(input vec_t v);
    int rises, done_at, lat_cnt;
    logic [7:0] s0, s15;
    logic prev_sclk;
    rises = 0; done_at = -1; lat_cnt = 0; s0 = '0; s15 = '0; prev_sclk = 1'b0;
    a_data = mk_word(v.base);
    a_valid = 1'b1;
    @(posedge clk);
    #1 a_valid = 1'b0;
    for (int k = 1; k <= 24; k++) begin
      tick();
      if (a_sclk && !prev_sclk) begin
        s0  = {a_sdata[0], s0[7:1]};
        s15 = {a_sdata[15], s15[7:1]};
        rises++;
      end
      prev_sclk = a_sclk;
      if (a_latch) lat_cnt++;
      if (a_done && done_at < 0) done_at = k;
    end
    check("vec_sclk_rises", 64'(rises), 64'(8));
    check("vec_lane0_bits", 64'(s0), 64'(v.exp0));
    check("vec_lane15_bits", 64'(s15), 64'(v.exp15));
    check("vec_done_cycle", 64'(done_at), 64'(v.exp_done));
    check("vec_latch_cycles", 64'(lat_cnt), 64'(LATC));
    check("vec_idle_after", 64'(a_busy), 64'(0));
  endtask

  initial begin
    int nacc, nlat, idle_gap, ready_low, lat_cnt, c0, k, nr, nd, hi_run, bad_runs, nfalls;
    int lat_t[3];
    int rise_t[8];
    int done_t[2];
    logic prev_lat, prev_sclk, found;
    logic [7:0] s0, s1;
    logic [CH*BITS-1:0] w_new;

    vecs[0] = '{base: 8'hA5, exp0: 8'hA5, exp15: 8'hAA, exp_done: 18};
    vecs[1] = '{base: 8'h00, exp0: 8'h00, exp15: 8'h0F, exp_done: 18};
    vecs[2] = '{base: 8'hFF, exp0: 8'hFF, exp15: 8'hF0, exp_done: 18};
    vecs[3] = '{base: 8'h3C, exp0: 8'h3C, exp15: 8'h33, exp_done: 18};

    #2 rst_n = 1'b0;
    #10;
    check("rst_sdata", 64'(a_sdata), 64'(0));
    check("rst_sclk_latch_done", 64'({a_sclk, a_latch, a_done}), 64'(0));
    check("rst_busy", 64'(a_busy), 64'(0));
    check("rst_ready", 64'(a_ready), 64'(1));
    #11 rst_n = 1'b1;
    tick();
    tick();

    for (int i = 0; i < 4; i++) run_vec(vecs[i]);

    // Random single frames, scored cycle by cycle.
    for (int i = 0; i < 3; i++) begin
      for (int c = 0; c < CH*BITS; c += 32) a_data[c +: 32] = $urandom;
      a_valid = 1'b1;
      @(posedge clk);
      #1 a_valid = 1'b0;
      for (int j = 0; j < 22 + $urandom_range(0, 3); j++) tick();
    end

    // Back-to-back frames with in_valid held high.
    nacc = 0; nlat = 0; idle_gap = 0; ready_low = 0; prev_lat = 1'b0;
    a_data = mk_word(8'h11);
    a_valid = 1'b1;
    for (int j = 0; j < 90 && nlat < 3; j++) begin
      tick();
      if (a_latch && !prev_lat) begin
        lat_t[nlat] = cyc;
        nlat++;
      end
      prev_lat = a_latch;
      if (nacc > 0 && !a_busy && nlat < 3) idle_gap++;
      if (nacc > 0 && !a_ready) ready_low++;
      if (a_valid && a_ready) begin
        @(posedge clk);
        #1;
        nacc++;
        a_data = mk_word(8'h11 + 8'(nacc) * 8'h22);
        if (nacc == 3) a_valid = 1'b0;
      end
    end
    check("b2b_latch_pulses", 64'(nlat), 64'(3));
    check("b2b_spacing_1", 64'(lat_t[1] - lat_t[0]), 64'(PER));
    check("b2b_spacing_2", 64'(lat_t[2] - lat_t[1]), 64'(PER));
    check("b2b_idle_gap", 64'(idle_gap), 64'(0));
    check("b2b_ready_low_seen", 64'(ready_low > 0), 64'(1));
    a_valid = 1'b0;
    for (int j = 0; j < 24; j++) tick();

    // New frame offered exactly on the final latch cycle.
    a_data = mk_word(8'h5A);
    a_valid = 1'b1;
    @(posedge clk);
    #1 a_valid = 1'b0;
    found = 1'b0;
    for (int j = 0; j < 40 && !found; j++) begin
      tick();
      if (a_done) found = 1'b1;
    end
    check("last_latch_seen", 64'(found), 64'(1));
    w_new = mk_word(8'hC3);
    a_data = w_new;
    a_valid = 1'b1;
    @(posedge clk);
    #1 a_valid = 1'b0;
    tick();
    check("last_latch_busy", 64'(a_busy), 64'(1));
    check("last_latch_shift_start", 64'({a_latch, a_sclk}), 64'(0));
    check("last_latch_new_bit0", 64'(a_sdata), 64'(bit0_lanes(w_new)));
    for (int j = 0; j < 24; j++) tick();

    // Reset asserted seven cycles into a frame.
    a_data = mk_word(8'h77);
    a_valid = 1'b1;
    @(posedge clk);
    #1 a_valid = 1'b0;
    for (int j = 0; j < 6; j++) tick();
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("abort_outputs", 64'({a_sdata, a_sclk, a_latch, a_busy, a_done}), 64'(0));
    check("abort_ready", 64'(a_ready), 64'(1));
    tick();
    tick();
    #2 rst_n = 1'b1;
    lat_cnt = 0;
    for (int j = 0; j < 25; j++) begin
      tick();
      if (a_latch) lat_cnt++;
    end
    check("abort_no_latch", 64'(lat_cnt), 64'(0));
    run_vec(vecs[0]);

    // Slow instance: DIV=3, BITS=4, two queued frames.
    nr = 0; nd = 0; hi_run = 0; bad_runs = 0; nfalls = 0; s0 = '0; s1 = '0; prev_sclk = 1'b0;
    b_data = 8'h69;
    b_valid = 1'b1;
    c0 = cyc;
    for (int j = 0; j < 60; j++) begin
      tick();
      k = cyc - c0;
      if (k == 1) b_data = 8'hC3;
      if (k == 2) b_valid = 1'b0;
      if (b_sclk && !prev_sclk) begin
        if (nr < 8) rise_t[nr] = k;
        s0 = {b_sdata[0], s0[7:1]};
        s1 = {b_sdata[1], s1[7:1]};
        nr++;
      end
      if (b_sclk) hi_run++;
      else if (prev_sclk) begin
        if (hi_run != B_DIV) bad_runs++;
        nfalls++;
        hi_run = 0;
      end
      prev_sclk = b_sclk;
      if (b_done && nd < 2) begin
        done_t[nd] = k;
        nd++;
      end
    end
    check("slow_rises", 64'(nr), 64'(8));
    check("slow_first_rise", 64'(rise_t[0]), 64'(B_DIV + 1));
    check("slow_bit_period", 64'(rise_t[1] - rise_t[0]), 64'(2 * B_DIV));
    check("slow_frame_period", 64'(rise_t[4] - rise_t[0]), 64'(26));
    check("slow_high_runs", 64'(bad_runs), 64'(0));
    check("slow_falls", 64'(nfalls), 64'(8));
    check("slow_done_1", 64'(done_t[0]), 64'(26));
    check("slow_done_2", 64'(done_t[1]), 64'(52));
    check("slow_lane0_bits", 64'(s0), 64'(8'h39));
    check("slow_lane1_bits", 64'(s1), 64'(8'hC6));

    $display("Result: errors=%0d of %0d checks", errors, n_checks);
    $finish;
  end

endmodule
